afifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter placed in front of an `afifo` write port. It shares that port among `NUM_REQ` requesters and grants one requester at a time for a whole burst of `req_len` words. It paces writes against the FIFO's `full` and `almost_full` flags. It runs entirely in the FIFO's write-clock domain: `clk` is the same net as the FIFO `din_clk`.

---
 rtl/afifo_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_afifo_wr_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_wr_arbiter.sv
// Round-robin arbiter sharing one afifo write port among NUM_REQ burst requesters.
// Grants a whole burst at a time; paces writes with the FIFO full/almost_full flags.
module afifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              ack,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            busy,
  output logic [DATA_WIDTH-1:0]           fifo_data_in,
  output logic                            fifo_wr_en,
  input  logic                            fifo_full,
  input  logic                            fifo_almost_full
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state, state_d;
  logic [NUM_REQ-1:0]     gnt_d;
  logic [PTR_W-1:0]       ptr, ptr_d;
  logic [LEN_WIDTH-1:0]   cnt, cnt_d;

  logic [NUM_REQ-1:0]     eligible;
  logic                   found;
  logic [PTR_W-1:0]       sel;
  logic [LEN_WIDTH-1:0]   sel_len;
  int                     rr_idx;
  logic [DATA_WIDTH-1:0]  gnt_data;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req[i] && (req_len[i*LEN_WIDTH +: LEN_WIDTH] != '0);
    end
  end

  // First eligible lane at or after ptr, wrapping past the top lane.
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    sel_len = '0;
    rr_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = int'(ptr) + k;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (!found && eligible[rr_idx]) begin
        found   = 1'b1;
        sel     = PTR_W'(rr_idx);
        sel_len = req_len[rr_idx*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_data = gnt_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    // NOTE: every next-state and output variable gets a default first so no path infers a latch.
    state_d      = state;
    gnt_d        = gnt;
    ptr_d        = ptr;
    cnt_d        = cnt;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    ack          = '0;
    unique case (state)
      IDLE: begin
        if (found && !fifo_almost_full) begin
          state_d = BURST;
          gnt_d   = NUM_REQ'(1) << sel;
          cnt_d   = sel_len;
          ptr_d   = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + PTR_W'(1);
        end
      end
      BURST: begin
        // almost_full is deliberately ignored here; only full stalls a burst in flight.
        fifo_wr_en   = ~fifo_full;
        fifo_data_in = gnt_data;
        ack          = gnt & {NUM_REQ{~fifo_full}};
        if (!fifo_full && cnt != '0) begin
          cnt_d = cnt - LEN_WIDTH'(1);
          if (cnt == LEN_WIDTH'(1)) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
    end
  end

  assign busy = (state == BURST);

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Self-checking bench for afifo_wr_arbiter: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a transaction-level model of the arbitration rules.
module tb_afifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int OW = N + 1 + 1 + N + DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*LW-1:0]   req_len;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      ack;
  logic [N-1:0]      gnt;
  logic              busy;
  logic [DW-1:0]     fifo_data_in;
  logic              fifo_wr_en;
  logic              fifo_full;
  logic              fifo_almost_full;

  afifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_data(req_data),
    .ack(ack), .gnt(gnt), .busy(busy), .fifo_data_in(fifo_data_in),
    .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full)
  );

  always #5 clk = ~clk;

  logic [OW-1:0] obs;
  assign obs = {gnt, busy, fifo_wr_en, ack, fifo_data_in};

  typedef struct {
    logic [N-1:0]  gnt;
    logic          busy;
    logic          wr;
    logic [N-1:0]  ack;
    logic [DW-1:0] data;
  } cyc_t;

  cyc_t         log_q[$];
  logic [N-1:0] last_ack;
  int           checks = 0;
  int           passes = 0;

  // Model: a burst in progress is (lane, words left); the next search starts at m_next.
  bit m_active;
  int m_lane;
  int m_left;
  int m_next;

  function automatic logic [OW-1:0] model_out();
    logic [N-1:0]  g;
    logic          w;
    if (!m_active) return '0;
    g = N'(1) << m_lane;
    w = !fifo_full;
    return {g, 1'b1, w, (w ? g : {N{1'b0}}), req_data[m_lane*DW +: DW]};
  endfunction

  function automatic int lane_len(int l);
    return int'(req_len[l*LW +: LW]);
  endfunction

  task automatic set_len(input int l, input int v);
    req_len[l*LW +: LW] = LW'(v);
  endtask

  task automatic sample();
    cyc_t c;
    c.gnt = gnt; c.busy = busy; c.wr = fifo_wr_en; c.ack = ack; c.data = fifo_data_in;
    log_q.push_back(c);
    last_ack = ack;
  endtask

  // Clock edge: update the model from the inputs the DUT just sampled, then let
  // each requester present its next word if its current one was accepted.
  task automatic advance();
    int l;
    @(posedge clk);
    if (rst) begin
      m_active = 0; m_next = 0; m_left = 0;
    end else if (!m_active) begin
      if (!fifo_almost_full) begin
        for (int k = 0; k < N; k++) begin
          l = (m_next + k) % N;
          if (!m_active && req[l] && lane_len(l) != 0) begin
            m_active = 1; m_lane = l; m_left = lane_len(l); m_next = (l + 1) % N;
          end
        end
      end
    end else if (!fifo_full) begin
      m_left--;
      if (m_left == 0) m_active = 0;
    end
    #1;
    for (int i = 0; i < N; i++)
      if (last_ack[i]) req_data[i*DW +: DW] = req_data[i*DW +: DW] + 8'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_len = '0; fifo_full = 1'b0; fifo_almost_full = 1'b0;
    last_ack = '0;
    advance();
    advance();
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (obs !== '0) $display("FAIL reset_outputs got %h want 0", obs); else passes++;
    checks++;
    if (obs !== model_out()) $display("FAIL reset_model got %h want %h", obs, model_out()); else passes++;
    advance();
  endtask

  task automatic test_single_burst();
    int n_gnt, n_wr, k;
    do_reset();
    req_data[0 +: DW] = 8'hA0;
    for (int i = 0; i < 6; i++) begin
      req = (i == 0) ? 4'b0001 : 4'b0000;
      set_len(0, 3);
      @(negedge clk); sample();
      checks++;
      if (obs !== model_out()) $display("FAIL single_burst cyc %0d got %h want %h", i, obs, model_out()); else passes++;
      advance();
    end
    n_gnt = 0; n_wr = 0; k = 0;
    foreach (log_q[j]) begin
      if (log_q[j].gnt == 4'b0001) n_gnt++;
      if (log_q[j].wr) begin
        n_wr++;
        checks++;
        if (log_q[j].data !== 8'(8'hA0 + k)) $display("FAIL single_data word %0d got %h want %h", k, log_q[j].data, 8'(8'hA0 + k)); else passes++;
        k++;
      end
    end
    checks++;
    if (n_gnt != 3) $display("FAIL single_gnt_cycles got %0d want 3", n_gnt); else passes++;
    checks++;
    if (n_wr != 3) $display("FAIL single_wr_cycles got %0d want 3", n_wr); else passes++;
    checks++;
    if (log_q[5].busy !== 1'b0) $display("FAIL single_busy_end got %b want 0", log_q[5].busy); else passes++;
    // Pointer now sits at lane 1, so with lanes 0 and 1 both asking, lane 1 wins.
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      req = (i == 0) ? 4'b0011 : 4'b0000;
      set_len(0, 1); set_len(1, 1);
      @(negedge clk); sample();
      checks++;
      if (obs !== model_out()) $display("FAIL single_ptr cyc %0d got %h want %h", i, obs, model_out()); else passes++;
      advance();
    end
    checks++;
    if (log_q[1].gnt !== 4'b0010) $display("FAIL single_ptr_next got %b want 0010", log_q[1].gnt); else passes++;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] order[$];
    int runs_on[$];
    int runs_off[$];
    int run;
    logic prev;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      req = (i < 15) ? 4'b1111 : 4'b0000;
      for (int l = 0; l < N; l++) set_len(l, 2);
      @(negedge clk); sample();
      checks++;
      if (obs !== model_out()) $display("FAIL round_robin cyc %0d got %h want %h", i, obs, model_out()); else passes++;
      advance();
    end
    prev = 1'b0; run = 0;
    for (int j = 1; j < 15; j++) begin
      if ((log_q[j].gnt != 0) != prev) begin
        if (prev) runs_on.push_back(run); else if (j > 1) runs_off.push_back(run);
        if (!prev) order.push_back(log_q[j].gnt);
        prev = (log_q[j].gnt != 0); run = 0;
      end
      run++;
    end
    if (prev) runs_on.push_back(run);
    checks++;
    if (order.size() != 5) $display("FAIL rr_bursts got %0d want 5", order.size()); else passes++;
    for (int j = 0; j < order.size() && j < 5; j++) begin
      checks++;
      if (order[j] !== N'(1) << (j % N)) $display("FAIL rr_order burst %0d got %b want %b", j, order[j], N'(1) << (j % N)); else passes++;
    end
    foreach (runs_on[j]) begin
      checks++;
      if (runs_on[j] != 2) $display("FAIL rr_burst_len burst %0d got %0d want 2", j, runs_on[j]); else passes++;
    end
    foreach (runs_off[j]) begin
      checks++;
      if (runs_off[j] != 1) $display("FAIL rr_gap gap %0d got %0d want 1", j, runs_off[j]); else passes++;
    end
  endtask

  task automatic test_full_stall();
    int n_wr;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      req = (i == 0) ? 4'b0010 : 4'b0000;
      set_len(1, 4);
      fifo_full = (i == 3 || i == 4);
      @(negedge clk); sample();
      checks++;
      if (obs !== model_out()) $display("FAIL full_stall cyc %0d got %h want %h", i, obs, model_out()); else passes++;
      advance();
    end
    fifo_full = 1'b0;
    for (int j = 3; j <= 4; j++) begin
      checks++;
      if (log_q[j].gnt !== 4'b0010 || log_q[j].wr !== 1'b0 || log_q[j].ack !== 4'b0000)
        $display("FAIL stall_hold cyc %0d got gnt=%b wr=%b ack=%b want gnt=0010 wr=0 ack=0000", j, log_q[j].gnt, log_q[j].wr, log_q[j].ack);
      else passes++;
    end
    n_wr = 0;
    foreach (log_q[j]) if (log_q[j].wr) n_wr++;
    checks++;
    if (n_wr != 4) $display("FAIL stall_words got %0d want 4", n_wr); else passes++;
  endtask

  task automatic test_almost_full();
    int n_gnt;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      fifo_almost_full = (i < 10);
      req = (i <= 10) ? 4'b0100 : 4'b0000;
      set_len(2, 1);
      @(negedge clk); sample();
      checks++;
      if (obs !== model_out()) $display("FAIL almost_full cyc %0d got %h want %h", i, obs, model_out()); else passes++;
      advance();
    end
    n_gnt = 0;
    for (int j = 0; j <= 10; j++) if (log_q[j].gnt != 0) n_gnt++;
    checks++;
    if (n_gnt != 0) $display("FAIL af_no_grant got %0d granted cycles want 0", n_gnt); else passes++;
    checks++;
    if (log_q[11].gnt !== 4'b0100) $display("FAIL af_release got %b want 0100", log_q[11].gnt); else passes++;
  endtask

  task automatic test_zero_length();
    int n_lane0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req = 4'b0011;
      set_len(0, 0); set_len(1, 1);
      @(negedge clk); sample();
      checks++;
      if (obs !== model_out()) $display("FAIL zero_length cyc %0d got %h want %h", i, obs, model_out()); else passes++;
      advance();
    end
    req = '0;
    n_lane0 = 0;
    foreach (log_q[j]) if (log_q[j].gnt[0]) n_lane0++;
    checks++;
    if (n_lane0 != 0) $display("FAIL zero_len_lane0 got %0d cycles want 0", n_lane0); else passes++;
    checks++;
    if (log_q[1].gnt !== 4'b0010) $display("FAIL zero_len_lane1 got %b want 0010", log_q[1].gnt); else passes++;
  endtask

  task automatic test_reset_mid_burst();
    int n_ack;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req = (i == 0) ? 4'b0001 : (i >= 7 ? 4'b0011 : 4'b0000);
      set_len(0, (i == 0) ? 5 : 1); set_len(1, 1);
      rst = (i == 2);
      @(negedge clk); sample();
      checks++;
      if (obs !== model_out()) $display("FAIL reset_mid cyc %0d got %h want %h", i, obs, model_out()); else passes++;
      advance();
    end
    rst = 1'b0; req = '0;
    checks++;
    if (log_q[2].wr !== 1'b1) $display("FAIL rm_second_word got wr=%b want 1", log_q[2].wr); else passes++;
    checks++;
    if (log_q[3].gnt !== 0 || log_q[3].busy !== 0 || log_q[3].wr !== 0)
      $display("FAIL rm_after got gnt=%b busy=%b wr=%b want 0/0/0", log_q[3].gnt, log_q[3].busy, log_q[3].wr);
    else passes++;
    n_ack = 0;
    for (int j = 3; j <= 7; j++) if (log_q[j].ack != 0) n_ack++;
    checks++;
    if (n_ack != 0) $display("FAIL rm_no_ack got %0d ack cycles want 0", n_ack); else passes++;
    checks++;
    if (log_q[8].gnt !== 4'b0001) $display("FAIL rm_ptr_zero got %b want 0001", log_q[8].gnt); else passes++;
  endtask

  task automatic test_random();
    do_reset();
    for (int l = 0; l < N; l++) req_data[l*DW +: DW] = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      req = N'($urandom);
      for (int l = 0; l < N; l++) set_len(l, $urandom_range(0, 4));
      fifo_full        = ($urandom_range(0, 3) == 0);
      fifo_almost_full = ($urandom_range(0, 4) == 0);
      rst              = ($urandom_range(0, 99) == 0);
      @(negedge clk); sample();
      checks++;
      if (obs !== model_out()) $display("FAIL random cyc %0d got %h want %h", i, obs, model_out()); else passes++;
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    m_active = 0; m_lane = 0; m_left = 0; m_next = 0;
    req_data = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_almost_full();
    test_zero_length();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
